// File: rtl/furv_pkg.sv
// rtl/furv_pkg.sv - shared types and constants for the furv_mc core
package furv_pkg;

  localparam int XLEN = 32;

  // Core sequencing states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Branch comparison kinds, taken from comparison[2:1]; 1 and 3 are both unsigned
  localparam logic [1:0] CMP_EQ   = 2'd0;
  localparam logic [1:0] CMP_LTU  = 2'd1;
  localparam logic [1:0] CMP_LT   = 2'd2;
  localparam logic [1:0] CMP_LTU3 = 2'd3;

  // Major opcodes understood by the decoder
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  // Decoded instruction; register fields an instruction does not use read as 0
  typedef struct packed {
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            imm_b;
    logic            branch;
    logic            mem;
    logic            mem_read;
    logic            wb;
    logic [2:0]      comparison;
    alu_op_e         alu_op;
  } dec_t;

  // Register-register / register-immediate ALU selection from funct3
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/furv_alu.sv
// rtl/furv_alu.sv - combinational ALU shared with the single-cycle furv
module furv_alu
  import furv_pkg::*;
(
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Result select
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {31'b0, a_i < b_i};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/furv_decoder.sv
// rtl/furv_decoder.sv - instruction decoder shared with the single-cycle furv
module furv_decoder
  import furv_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output dec_t            dec_o
);

  logic [6:0] opcode;
  logic [2:0] f3;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];

  // Field extraction per opcode; unknown opcodes decode as a plain pc+4 no-op
  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    case (opcode)
      OPC_OP_IMM: begin
        dec_o.ra     = instr_i[19:15];
        dec_o.rd     = instr_i[11:7];
        dec_o.imm    = {{20{instr_i[31]}}, instr_i[31:20]};
        dec_o.imm_b  = 1'b1;
        dec_o.wb     = 1'b1;
        dec_o.alu_op = alu_sel(f3, (f3 == 3'b101) && instr_i[30]);
      end
      OPC_OP: begin
        dec_o.ra     = instr_i[19:15];
        dec_o.rb     = instr_i[24:20];
        dec_o.rd     = instr_i[11:7];
        dec_o.wb     = 1'b1;
        dec_o.alu_op = alu_sel(f3, instr_i[30]);
      end
      OPC_LOAD: begin
        dec_o.ra       = instr_i[19:15];
        dec_o.rd       = instr_i[11:7];
        dec_o.imm      = {{20{instr_i[31]}}, instr_i[31:20]};
        dec_o.imm_b    = 1'b1;
        dec_o.mem      = 1'b1;
        dec_o.mem_read = 1'b1;
        dec_o.wb       = 1'b1;
      end
      OPC_STORE: begin
        dec_o.ra    = instr_i[19:15];
        dec_o.rb    = instr_i[24:20];
        dec_o.imm   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        dec_o.imm_b = 1'b1;
        dec_o.mem   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.ra         = instr_i[19:15];
        dec_o.rb         = instr_i[24:20];
        dec_o.imm        = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
        dec_o.imm_b      = 1'b1;
        dec_o.branch     = 1'b1;
        dec_o.comparison = f3;
      end
      OPC_LUI: begin
        // ra stays 0 so the adder sees x0 + imm
        dec_o.rd    = instr_i[11:7];
        dec_o.imm   = {instr_i[31:12], 12'h000};
        dec_o.imm_b = 1'b1;
        dec_o.wb    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/furv_regfile.sv
// rtl/furv_regfile.sv - 2R/1W register file with hardwired x0
module furv_regfile
  import furv_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] ra_i,
  input  logic [$clog2(NREGS)-1:0] rb_i,
  output logic [XLEN-1:0]          ra_data_o,
  output logic [XLEN-1:0]          rb_data_o,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] wa_i,
  input  logic [XLEN-1:0]          wd_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  assign ra_data_o = (ra_i == '0) ? '0 : regs_q[ra_i];
  assign rb_data_o = (rb_i == '0) ? '0 : regs_q[rb_i];

  // Storage: async clear, writes to x0 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/furv_mc.sv
// rtl/furv_mc.sv - multi-cycle furv core with req/ack fetch and data ports
module furv_mc
  import furv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam int AW = $clog2(NREGS);

  state_e           state_q, state_d;
  logic             run_q;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  daddr_q, daddr_d;
  logic [XLEN-1:0]  dwdata_q, dwdata_d;
  logic             dwe_q, dwe_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  dec_t            dec;
  logic [XLEN-1:0] rs_a, rs_b, alu_a, alu_b, alu_y;
  logic            cc, taken, illegal;
  logic            rf_we;
  logic [XLEN-1:0] rf_wd;

  furv_decoder u_dec (
    .instr_i (ir_q),
    .dec_o   (dec)
  );

  furv_regfile #(.NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_i      (dec.ra[AW-1:0]),
    .rb_i      (dec.rb[AW-1:0]),
    .ra_data_o (rs_a),
    .rb_data_o (rs_b),
    .we_i      (rf_we),
    .wa_i      (dec.rd[AW-1:0]),
    .wd_i      (rf_wd)
  );

  assign alu_a = dec.branch ? pc_q : rs_a;
  assign alu_b = dec.imm_b  ? dec.imm : rs_b;

  furv_alu u_alu (
    .op_i (dec.alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  // Branch condition on the register operands, independent of the ALU operands
  always_comb begin
    cc = 1'b0;
    case (dec.comparison[2:1])
      CMP_EQ:  cc = (rs_a == rs_b);
      CMP_LT:  cc = ($signed(rs_a) < $signed(rs_b));
      default: cc = (rs_a < rs_b);
    endcase
  end

  assign taken   = dec.branch & (cc ^ dec.comparison[0]);
  assign illegal = (NREGS == 16) && (dec.ra[4] || dec.rb[4] || dec.rd[4]);

  // run_q holds the fetch request off for the first cycle after reset release
  assign imem_req   = run_q && (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign halted     = (state_q == HALT);
  assign instret    = instret_q;

  // Next-state, datapath updates and register write port
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    dwe_d     = dwe_q;
    instret_d = instret_q;
    rf_we     = 1'b0;
    rf_wd     = alu_y;
    case (state_q)
      FETCH: begin
        if (imem_req && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (illegal) begin
          state_d = HALT;
        end else if (dec.mem) begin
          daddr_d  = alu_y;
          dwdata_d = rs_b;
          dwe_d    = ~dec.mem_read;
          state_d  = MEM;
        end else begin
          rf_we     = dec.wb;
          pc_d      = taken ? alu_y : pc_q + 32'd4;
          instret_d = instret_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          rf_we     = dec.mem_read & dec.wb;
          rf_wd     = dmem_rdata;
          pc_d      = pc_q + 32'd4;
          instret_d = instret_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      dwe_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      dwe_q     <= dwe_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: doc/furv_mc.md
Name: furv_mc

Overview:
Multi-cycle, parametrised successor to the single-cycle furv core. It executes the same decoder/alu instruction set. Instruction fetch and data access go through separate req/ack handshake ports, so memories with arbitrary latency can be attached. It adds an asynchronous reset, a hardwired-zero x0, an RV32E-style reduced register file option, an illegal-register halt, and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, pc value loaded on reset.
NREGS, 32, architectural register count; legal values are 16 or 32.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
imem_req  out  1  fetch request; held until imem_ack.
imem_addr  out  32  fetch address, equal to pc.
imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
imem_rdata  in  32  instruction word.
dmem_req  out  1  data request; held until dmem_ack.
dmem_we  out  1  1 = store, 0 = load.
dmem_addr  out  32  ALU result latched in EXEC.
dmem_wdata  out  32  r[rb] latched in EXEC.
dmem_ack  in  1  data complete; dmem_rdata is valid with ack for loads.
dmem_rdata  in  32  load data.
halted  out  1  sticky; core stopped on an illegal register index.
instret  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, state = FETCH.
  - All registers = 0; instret = 0; halted = 0.
  - imem_req, dmem_req and dmem_we = 0.
  - On rst_n deassertion, the first fetch request is made in the next cycle.
- FSM states: FETCH, EXEC, MEM, HALT.
- FETCH:
  - Assert imem_req with imem_addr = pc.
  - On imem_ack, latch imem_rdata into ir and go to EXEC; imem_req drops in the next cycle.
- EXEC (exactly 1 cycle), working on ir through the existing decoder:
  - ALU A operand = pc if branch, else r[ra]. ALU B operand = imm if imm_b, else r[rb].
  - Compare: cop = comparison[2:1]. cop 0 is r[ra]==r[rb]; cop 2 is signed r[ra]<r[rb]; otherwise unsigned r[ra]<r[rb].
  - taken = branch & (cc ^ comparison[0]).
  - Illegal register check: if NREGS==16 and any of ra/rb/rd has bit4 set, go to HALT with no writeback and no pc change.
  - If mem: latch dmem_addr = d, dmem_wdata = r[rb], dmem_we = ~mem_read, then go to MEM.
  - Otherwise: if wb, r[rd] = d. pc = taken ? d : pc+4. instret += 1. Go to FETCH.
- MEM:
  - Assert dmem_req with stable addr, wdata and we until dmem_ack.
  - On ack: a load with wb writes r[rd] = dmem_rdata. Then pc += 4, instret += 1, go to FETCH.
- HALT: absorbing state. halted = 1, no requests; only reset leaves it.
- Register x0:
  - Writes to x0 are discarded; reads of x0 return 0.
  - Unlike furv there is no r[1]=1 preset.
- Handshake rules:
  - An ack in the same cycle as the req rise is legal; best-case latency is 2 cycles per ALU op and 3 per load/store.
  - An ack while req is low is ignored.
  - At most one request is outstanding, and never both ports at once.
- Reset mid-transaction: the request drops immediately, and a late ack after reset is ignored.
- pc arithmetic is modulo 2^32 (0xFFFF_FFFC + 4 = 0). Alignment is not checked.

Decomposition:
- furv_pkg: state enum (FETCH/EXEC/MEM/HALT), cop encodings (CMP_EQ=0, CMP_LT=2, CMP_LTU=1/3), width constant XLEN=32.
- One natural sub-module, furv_regfile, parameterised by NREGS:
  - 2 combinational read ports and 1 synchronous write port.
  - x0 is hardwired; asynchronous clear on rst_n.
- Reuse the existing decoder and alu unchanged.

Test Plan:
- Reset and first fetch: release reset with RESET_PC=0x100 and zero-latency ack -> imem_addr=0x100 in the first FETCH cycle; after an addi x1,x0,5 retires, r1=5 and instret=1.
- Wait states: imem_ack delayed 3 cycles and dmem_ack delayed 2 cycles -> req stays high and addr stays stable throughout; a load from 0x40 returning 0xDEADBEEF writes rd=0xDEADBEEF and pc advances by exactly 4.
- Branches: beq with r1=r2=7 and imm=-8 at pc 0x20 -> next pc 0x18. bltu with r1=0xFFFF_FFFF, r2=1 -> not taken, next pc 0x24. blt with the same operands -> taken.
- x0 and store: write to x0 -> x0 reads 0. sw with r3=0x1234 at addr 0x80 -> dmem_we=1, dmem_wdata=0x1234, no register write.
- NREGS=16: instruction with rd=17 -> halted=1 one cycle after EXEC, no further imem_req, instret unchanged; asserting rst_n low clears halted.
- Async reset during MEM with dmem_req high -> dmem_req=0 immediately, pc=RESET_PC; an ack arriving after reset has no effect.
